// File: rtl/pipe_pkg.sv
// Shared pipeline-control types: sequencer state encoding, register-zero constant
// and the per-stage enable/flush bundles (stage order PC, ID, EX, MEM, WB).
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_DMEM_WAIT = 2'd1,
        ST_ERROR     = 2'd2
    } hz_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic pc;
        logic id;
        logic ex;
        logic mem;
        logic wb;
    } stage_we_t;

    typedef struct packed {
        logic id;
        logic ex;
        logic mem;
    } stage_flush_t;

    typedef struct packed {
        stage_we_t    we;
        stage_flush_t flush;
        logic         redirect;
    } seq_ctrl_t;

    localparam seq_ctrl_t CTRL_FREEZE = '0;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard compare between the load in EX and the ID operands.
module load_use_detect
    import pipe_pkg::*;
(
    input  logic       ex_mem_read,
    input  logic [4:0] ex_reg_addr,
    input  logic [4:0] id_reg_s,
    input  logic [4:0] id_reg_t,
    input  logic       id_uses_t,
    output logic       hazard
);

    logic match_s;
    logic match_t;

    assign match_s = (ex_reg_addr == id_reg_s);
    assign match_t = id_uses_t && (ex_reg_addr == id_reg_t);

    // A load into r0 is architecturally a no-op, so it can never feed a consumer.
    assign hazard = ex_mem_read && (ex_reg_addr != REG_ZERO) && (match_s || match_t);

endmodule

// File: rtl/hazard_ctrl.sv
// Central five-stage pipeline sequencer: stage enables, flushes, redirect and DMEM watchdog.
// Optional HAZARD_CTRL_PERF_EN adds live stall/flush performance counters.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_reg_s,
    input  logic [4:0]  id_reg_t,
    input  logic        id_uses_t,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_reg_addr,
    input  logic        mem_branch_taken,
    input  logic        mem_jump,
    input  logic        dmem_req,
    input  logic        dmem_ack,
    input  logic        imem_ready,
    output logic        we_pc,
    output logic        we_id,
    output logic        we_ex,
    output logic        we_mem,
    output logic        we_wb,
    output logic        flush_id,
    output logic        flush_ex,
    output logic        flush_mem,
    output logic        pc_sel_redirect,
    output logic        timeout_err,
    output logic [31:0] stall_count,
    output logic [31:0] flush_count
);

    hz_state_e state;
    hz_state_e state_nxt;
    logic [15:0] wait_cnt;
    logic [15:0] wait_cnt_nxt;
    logic [16:0] wait_inc;
    logic        load_use;
    logic        redirect_req;
    logic        dmem_hold;
    seq_ctrl_t   ctrl;
    seq_ctrl_t   ctrl_out;

    load_use_detect u_load_use_detect (
        .ex_mem_read (ex_mem_read),
        .ex_reg_addr (ex_reg_addr),
        .id_reg_s    (id_reg_s),
        .id_reg_t    (id_reg_t),
        .id_uses_t   (id_uses_t),
        .hazard      (load_use)
    );

    assign redirect_req = mem_branch_taken | mem_jump;
    assign dmem_hold    = dmem_req & ~dmem_ack;
    assign wait_inc     = {1'b0, wait_cnt} + 17'd1;

    // Priority resolution for a cycle in which data memory is not holding the pipe.
    function automatic seq_ctrl_t resolve(input logic redir, input logic lu, input logic imem_rdy);
        seq_ctrl_t c;
        c = CTRL_FREEZE;
        if (redir) begin
            c.we       = '1;
            c.flush    = '1;
            c.redirect = 1'b1;
        end else if (lu) begin
            c.we.mem   = 1'b1;
            c.we.wb    = 1'b1;
            c.we.ex    = 1'b1;
            c.flush.ex = 1'b1;
        end else if (!imem_rdy) begin
            c.we       = '1;
            c.we.pc    = 1'b0;
            c.flush.id = 1'b1;
        end else begin
            c.we       = '1;
        end
        return c;
    endfunction

    always_comb begin
        ctrl         = CTRL_FREEZE;
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            ST_RUN: begin
                if (dmem_hold) begin
                    state_nxt    = ST_DMEM_WAIT;
                    wait_cnt_nxt = '0;
                end else begin
                    ctrl = resolve(redirect_req, load_use, imem_ready);
                end
            end
            ST_DMEM_WAIT: begin
                // An ack on the same cycle the limit is reached still completes the access.
                if (dmem_ack) begin
                    ctrl      = resolve(redirect_req, load_use, imem_ready);
                    state_nxt = ST_RUN;
                end else begin
                    wait_cnt_nxt = wait_inc[15:0];
                    if (wait_inc == 17'(MEM_TIMEOUT)) begin
                        state_nxt = ST_ERROR;
                    end
                end
            end
            ST_ERROR: begin
                state_nxt = ST_ERROR;
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // Outputs are forced low combinationally so they drop the moment reset asserts.
    assign ctrl_out = reset ? ctrl : CTRL_FREEZE;

    assign we_pc           = ctrl_out.we.pc;
    assign we_id           = ctrl_out.we.id;
    assign we_ex           = ctrl_out.we.ex;
    assign we_mem          = ctrl_out.we.mem;
    assign we_wb           = ctrl_out.we.wb;
    assign flush_id        = ctrl_out.flush.id;
    assign flush_ex        = ctrl_out.flush.ex;
    assign flush_mem       = ctrl_out.flush.mem;
    assign pc_sel_redirect = ctrl_out.redirect;
    assign timeout_err     = reset && (state == ST_ERROR);

`ifdef HAZARD_CTRL_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if ((state != ST_ERROR) && !ctrl.we.pc) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (ctrl.redirect) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;
`else
    assign stall_count = '0;
    assign flush_count = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_hazard_ctrl;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [4:0]  id_reg_s, id_reg_t, ex_reg_addr;
    logic        id_uses_t, ex_mem_read, mem_branch_taken, mem_jump;
    logic        dmem_req, dmem_ack, imem_ready;
    logic        we_pc, we_id, we_ex, we_mem, we_wb;
    logic        flush_id, flush_ex, flush_mem, pc_sel_redirect, timeout_err;
    logic [31:0] stall_count, flush_count;

    logic [9:0] obs;
    logic [9:0] exp_vec;
    logic [9:0] exp_mask;

    int n_checks = 0;
    int n_fail = 0;

    // Behavioural model state
    bit m_wait;
    int m_wcnt;
    bit m_err;
    int m_stalls;
    int m_flushes;

    always #5 clk = ~clk;

    hazard_ctrl #(.MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .id_reg_s(id_reg_s), .id_reg_t(id_reg_t), .id_uses_t(id_uses_t),
        .ex_mem_read(ex_mem_read), .ex_reg_addr(ex_reg_addr),
        .mem_branch_taken(mem_branch_taken), .mem_jump(mem_jump),
        .dmem_req(dmem_req), .dmem_ack(dmem_ack), .imem_ready(imem_ready),
        .we_pc(we_pc), .we_id(we_id), .we_ex(we_ex), .we_mem(we_mem), .we_wb(we_wb),
        .flush_id(flush_id), .flush_ex(flush_ex), .flush_mem(flush_mem),
        .pc_sel_redirect(pc_sel_redirect), .timeout_err(timeout_err),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    assign obs = {we_pc, we_id, we_ex, we_mem, we_wb, flush_id, flush_ex, flush_mem,
                  pc_sel_redirect, timeout_err};

    function automatic logic [31:0] exp_stalls();
`ifdef HAZARD_CTRL_PERF_EN
        return 32'(m_stalls);
`else
        return 32'd0;
`endif
    endfunction

    function automatic logic [31:0] exp_flushes();
`ifdef HAZARD_CTRL_PERF_EN
        return 32'(m_flushes);
`else
        return 32'd0;
`endif
    endfunction

    task automatic idle_inputs();
        id_reg_s = 5'd1; id_reg_t = 5'd2; id_uses_t = 1'b0;
        ex_mem_read = 1'b0; ex_reg_addr = 5'd3;
        mem_branch_taken = 1'b0; mem_jump = 1'b0;
        dmem_req = 1'b0; dmem_ack = 1'b0; imem_ready = 1'b1;
    endtask

    task automatic model_reset();
        m_wait = 0; m_wcnt = 0; m_err = 0; m_stalls = 0; m_flushes = 0;
    endtask

    // Expected outputs for the current inputs; bit order matches obs, mask clears don't-care enables.
    task automatic model_eval();
        logic hz;
        exp_mask = '1;
        exp_vec  = '0;
        hz = ex_mem_read && (ex_reg_addr != 5'd0) &&
             ((ex_reg_addr == id_reg_s) || (id_uses_t && (ex_reg_addr == id_reg_t)));
        if (reset !== 1'b1) begin
            exp_vec = '0;
        end else if (m_err) begin
            exp_vec = 10'b0000000001;
        end else if ((m_wait && !dmem_ack) || (!m_wait && dmem_req && !dmem_ack)) begin
            exp_vec = '0;
        end else if (mem_branch_taken || mem_jump) begin
            exp_vec = 10'b1000111110; exp_mask = 10'b1000111111;
        end else if (hz) begin
            exp_vec = 10'b0001101000; exp_mask = 10'b1101111111;
        end else if (!imem_ready) begin
            exp_vec = 10'b0011110000; exp_mask = 10'b1011111111;
        end else begin
            exp_vec = 10'b1111100000;
        end
    endtask

    task automatic model_step();
        model_eval();
        if (reset === 1'b1 && !m_err) begin
            if (!exp_vec[9]) m_stalls++;
            if (exp_vec[1]) m_flushes++;
            if (m_wait) begin
                if (dmem_ack) m_wait = 0;
                else begin
                    m_wcnt++;
                    if (m_wcnt >= TMO) m_err = 1;
                end
            end else if (dmem_req && !dmem_ack) begin
                m_wait = 1;
                m_wcnt = 0;
            end
        end
    endtask

    task automatic advance();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        mem_branch_taken = 1'b1;
        ex_mem_read = 1'b1; ex_reg_addr = 5'd1;
        model_reset();
        @(negedge clk);
        n_checks++;
        if (obs !== 10'd0) begin
            n_fail++; $display("FAIL reset_outputs: got %b want %b", obs, 10'd0);
        end
        n_checks++;
        if (stall_count !== 32'd0 || flush_count !== 32'd0) begin
            n_fail++; $display("FAIL reset_counters: got %0d/%0d want 0/0", stall_count, flush_count);
        end
        idle_inputs();
        reset = 1'b1;
        advance();
    endtask

    task automatic test_load_use();
        // {ex_mem_read, ex_reg_addr, id_reg_s, id_reg_t, id_uses_t}
        logic [16:0] tbl [6];
        tbl = '{ {1'b1, 5'd5, 5'd5, 5'd9, 1'b0},
                 {1'b0, 5'd5, 5'd5, 5'd9, 1'b0},
                 {1'b1, 5'd0, 5'd0, 5'd0, 1'b1},
                 {1'b1, 5'd7, 5'd3, 5'd7, 1'b1},
                 {1'b1, 5'd7, 5'd3, 5'd7, 1'b0},
                 {1'b0, 5'd7, 5'd7, 5'd7, 1'b1} };
        for (int i = 0; i < 6; i++) begin
            {ex_mem_read, ex_reg_addr, id_reg_s, id_reg_t, id_uses_t} = tbl[i];
            @(negedge clk);
            model_eval();
            n_checks++;
            if ((obs & exp_mask) !== (exp_vec & exp_mask)) begin
                n_fail++; $display("FAIL load_use[%0d]: got %b want %b mask %b", i, obs, exp_vec, exp_mask);
            end
            advance();
        end
        idle_inputs();
    endtask

    task automatic test_branch();
        for (int i = 0; i < 3; i++) begin
            ex_mem_read = 1'b1; ex_reg_addr = 5'd5; id_reg_s = 5'd5;
            imem_ready = (i != 0);
            mem_branch_taken = (i != 1);
            mem_jump = (i == 1);
            @(negedge clk);
            model_eval();
            n_checks++;
            if ((obs & exp_mask) !== (exp_vec & exp_mask)) begin
                n_fail++; $display("FAIL branch[%0d]: got %b want %b mask %b", i, obs, exp_vec, exp_mask);
            end
            advance();
            idle_inputs();
            @(negedge clk);
            n_checks++;
            if (flush_count !== exp_flushes()) begin
                n_fail++; $display("FAIL branch_flush_count[%0d]: got %0d want %0d", i, flush_count, exp_flushes());
            end
            advance();
        end
    endtask

    task automatic test_dmem_wait();
        logic [31:0] s0;
        s0 = stall_count;
        dmem_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            dmem_ack = (i == 3);
            @(negedge clk);
            model_eval();
            n_checks++;
            if ((obs & exp_mask) !== (exp_vec & exp_mask)) begin
                n_fail++; $display("FAIL dmem_wait[%0d]: got %b want %b", i, obs, exp_vec);
            end
            advance();
        end
        idle_inputs();
        @(negedge clk);
        n_checks++;
`ifdef HAZARD_CTRL_PERF_EN
        if (stall_count - s0 !== 32'd3) begin
            n_fail++; $display("FAIL dmem_stall_delta: got %0d want 3", stall_count - s0);
        end
`else
        if (stall_count !== 32'd0 || s0 !== 32'd0) begin
            n_fail++; $display("FAIL dmem_stall_delta: got %0d want 0", stall_count);
        end
`endif
        // zero-wait access: req and ack together
        dmem_req = 1'b1; dmem_ack = 1'b1;
        @(negedge clk);
        model_eval();
        n_checks++;
        if (obs !== 10'b1111100000 || (obs & exp_mask) !== (exp_vec & exp_mask)) begin
            n_fail++; $display("FAIL dmem_zero_wait: got %b want %b", obs, 10'b1111100000);
        end
        advance();
        idle_inputs();
    endtask

    task automatic test_fetch_bubble();
        for (int i = 0; i < 3; i++) begin
            imem_ready = (i == 2);
            @(negedge clk);
            model_eval();
            n_checks++;
            if ((obs & exp_mask) !== (exp_vec & exp_mask)) begin
                n_fail++; $display("FAIL fetch_bubble[%0d]: got %b want %b mask %b", i, obs, exp_vec, exp_mask);
            end
            advance();
        end
        idle_inputs();
    endtask

    task automatic test_ack_at_timeout();
        dmem_req = 1'b1;
        for (int i = 0; i <= TMO + 1; i++) begin
            dmem_ack = (i == TMO);
            if (i == TMO + 1) dmem_req = 1'b0;
            @(negedge clk);
            model_eval();
            n_checks++;
            if ((obs & exp_mask) !== (exp_vec & exp_mask)) begin
                n_fail++; $display("FAIL ack_at_timeout[%0d]: got %b want %b", i, obs, exp_vec);
            end
            advance();
        end
        idle_inputs();
    endtask

    task automatic test_timeout();
        dmem_req = 1'b1;
        for (int i = 0; i < TMO + 6; i++) begin
            dmem_ack = (i == TMO + 3);
            @(negedge clk);
            model_eval();
            n_checks++;
            if ((obs & exp_mask) !== (exp_vec & exp_mask)) begin
                n_fail++; $display("FAIL timeout[%0d]: got %b want %b", i, obs, exp_vec);
            end
            n_checks++;
            if (stall_count !== exp_stalls()) begin
                n_fail++; $display("FAIL timeout_stalls[%0d]: got %0d want %0d", i, stall_count, exp_stalls());
            end
            advance();
        end
        idle_inputs();
        reset = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (obs !== 10'd0 || stall_count !== 32'd0) begin
            n_fail++; $display("FAIL timeout_reset_clear: got %b/%0d want 0/0", obs, stall_count);
        end
        @(negedge clk);
        reset = 1'b1;
        advance();
        @(negedge clk);
        model_eval();
        n_checks++;
        if (obs !== exp_vec) begin
            n_fail++; $display("FAIL timeout_after_reset: got %b want %b", obs, exp_vec);
        end
        advance();
    endtask

    task automatic test_reset_mid_wait();
        dmem_req = 1'b1;
        for (int i = 0; i < 3; i++) advance();
        reset = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (obs !== 10'd0) begin
            n_fail++; $display("FAIL reset_mid_wait_async: got %b want %b", obs, 10'd0);
        end
        idle_inputs();
        @(negedge clk);
        reset = 1'b1;
        advance();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            model_eval();
            n_checks++;
            if (obs !== 10'b1111100000 || obs !== exp_vec) begin
                n_fail++; $display("FAIL reset_mid_wait_release[%0d]: got %b want %b", i, obs, 10'b1111100000);
            end
            advance();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            if (i % 97 == 50) begin
                idle_inputs();
                reset = 1'b0;
                model_reset();
                #1;
                n_checks++;
                if (obs !== 10'd0 || stall_count !== 32'd0 || flush_count !== 32'd0) begin
                    n_fail++; $display("FAIL random_reset[%0d]: got %b", i, obs);
                end
                @(negedge clk);
                reset = 1'b1;
                advance();
            end
            ex_mem_read      = 1'($urandom_range(0, 1));
            ex_reg_addr      = 5'($urandom_range(0, 3));
            id_reg_s         = 5'($urandom_range(0, 3));
            id_reg_t         = 5'($urandom_range(0, 3));
            id_uses_t        = 1'($urandom_range(0, 1));
            mem_branch_taken = ($urandom_range(0, 7) == 0);
            mem_jump         = ($urandom_range(0, 11) == 0);
            dmem_req         = ($urandom_range(0, 2) == 0);
            dmem_ack         = ($urandom_range(0, 2) == 0);
            imem_ready       = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            model_eval();
            n_checks++;
            if ((obs & exp_mask) !== (exp_vec & exp_mask)) begin
                n_fail++; $display("FAIL random[%0d]: got %b want %b mask %b", i, obs, exp_vec, exp_mask);
            end
            n_checks++;
            if (stall_count !== exp_stalls() || flush_count !== exp_flushes()) begin
                n_fail++; $display("FAIL random_counters[%0d]: got %0d/%0d want %0d/%0d", i,
                                   stall_count, flush_count, exp_stalls(), exp_flushes());
            end
            advance();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_load_use();
        test_branch();
        test_dmem_wait();
        test_fetch_bubble();
        test_ack_at_timeout();
        test_timeout();
        test_reset_mid_wait();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Central pipeline sequencer for the five-stage core. It drives the per-stage write enables (`we`) and flush strobes for PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It resolves load-use hazards, branch/jump redirects resolved in MEM, instruction-fetch bubbles and multi-cycle data-memory waits, and includes a timeout watchdog. It sits beside the datapath and owns every stage's `we`; no stage computes its own stall.

## Interface
- `MEM_TIMEOUT`, default 255: DMEM_WAIT cycles tolerated before the sticky error; range 1..65535.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `id_reg_s`, `id_reg_t`  in  5 each  source registers of the instruction in ID.
- `id_uses_t`  in  1  ID instruction reads `reg_t` as an operand.
- `ex_mem_read`  in  1  instruction in EX is a load.
- `ex_reg_addr`  in  5  destination register of the EX instruction.
- `mem_branch_taken`  in  1  `is_branch_out & alu_zero` from EX/MEM.
- `mem_jump`  in  1  `is_jump_out` from EX/MEM.
- `dmem_req`  in  1  MEM stage accessing data memory (level).
- `dmem_ack`  in  1  data memory completes the access (1-cycle pulse).
- `imem_ready`  in  1  fetched instruction valid this cycle.
- `we_pc`, `we_id`, `we_ex`, `we_mem`, `we_wb`  out  1 each  capture enables.
- `flush_id`, `flush_ex`, `flush_mem`  out  1 each  load a bubble (control bits zero) into that register on the next edge; a flush overrides `we`.
- `pc_sel_redirect`  out  1  PC mux selects the branch/jump target.
- `timeout_err`  out  1  sticky watchdog error.
- `stall_count`, `flush_count`  out  32 each  performance counters.

## Operation
- FSM states:
  - RUN (reset state).
  - DMEM_WAIT.
  - ERROR.
- Outputs are combinational from state plus inputs.
- While `reset`=0:
  - All `we`, flush and `pc_sel_redirect` outputs are 0.
  - `timeout_err`=0; counters are 0.
- RUN evaluates conditions in priority order; the first match wins:
  1. `dmem_req & ~dmem_ack`: all `we`=0 and no flush. Go to DMEM_WAIT, wait counter cleared to 0.
  2. `mem_branch_taken | mem_jump`:
     - `we_pc`=1 and `pc_sel_redirect`=1.
     - `flush_id`=`flush_ex`=`flush_mem`=1 and `we_wb`=1.
     - This squashes the three younger instructions. It also overrides a simultaneous load-use stall and imem bubble.
  3. Load-use hazard:
     - Condition: `ex_mem_read`, `ex_reg_addr`≠0, and either `ex_reg_addr`==`id_reg_s` or (`id_uses_t` and `ex_reg_addr`==`id_reg_t`).
     - Response: `we_pc`=`we_id`=0, `flush_ex`=1, `we_mem`=`we_wb`=1.
  4. `~imem_ready`: `we_pc`=0, `flush_id`=1, and all later stages advance.
  5. Otherwise all `we`=1 and no flush.
- A `dmem_req` together with `dmem_ack` in the same cycle is a zero-wait access and is handled as not stalled.
- DMEM_WAIT:
  - All `we`=0; the wait counter increments every cycle.
  - On `dmem_ack`: that cycle behaves exactly as RUN rules 2–5, then the FSM returns to RUN.
  - If the counter reaches `MEM_TIMEOUT` with no ack, go to ERROR.
  - An ack arriving on the same cycle the counter reaches `MEM_TIMEOUT` wins.
- ERROR: all `we`=0, no flush, `timeout_err`=1. The block stays in ERROR until reset.
- The wait counter is 16 bits and cannot wrap: the timeout fires first.
- Register 0 never creates a load-use hazard.

## Timing
- Load-use stall lasts exactly 1 cycle. The next cycle re-evaluates with a bubble in EX, so no repeat stall occurs.
- Redirect:
  - The target is fetched the cycle after `mem_branch_taken`.
  - The branch penalty is 3 cycles.
  - `flush_count` increments once per redirect.
- DMEM access taking N cycles from `dmem_req` rise to `dmem_ack`:
  - N=1 (ack in the same cycle): no freeze.
  - N>1: pipeline freezes for N−1 cycles and advances on the ack cycle.
- `stall_count` increments on every cycle where `we_pc`=0, excluding ERROR.
- Reset deassertion: RUN becomes active on the first following edge.
- Reset asserted mid-wait immediately forces state to RUN and clears the wait counter and `timeout_err`.

## Configuration
- `HAZARD_CTRL_PERF_EN` defined: `stall_count` and `flush_count` are live 32-bit wrapping counters, cleared by reset.
- Not defined: both ports are tied to 0 and no counter flops are generated; all other behaviour is identical.

## Structure
- Shared package `pipe_pkg` holds:
  - FSM state encoding (RUN=2'd0, DMEM_WAIT=2'd1, ERROR=2'd2).
  - `REG_ZERO`=5'd0.
  - The stage-enable bundle ordering PC, ID, EX, MEM, WB, reused by the datapath top.
- Sub-module `load_use_detect`: purely combinational compare producing the rule-3 hazard bit, instantiated once.

## Test plan
- Load-use:
  - Stimulus: `ex_mem_read`=1, `ex_reg_addr`=5, `id_reg_s`=5.
  - Response: `we_pc`=`we_id`=0 and `flush_ex`=1 for 1 cycle. With `ex_reg_addr`=0, no stall.
- Branch:
  - Stimulus: `mem_branch_taken`=1 while a load-use condition is also present.
  - Response: `pc_sel_redirect`=1, all three flushes=1, no stall; `flush_count` 0→1 (with `HAZARD_CTRL_PERF_EN`).
- DMEM wait:
  - Stimulus: `dmem_req` held, ack after 4 cycles.
  - Response: all `we`=0 for 3 cycles, all `we`=1 on the ack cycle; `stall_count`=3.
- Timeout:
  - Stimulus: `MEM_TIMEOUT`=8, `dmem_req` held, no ack.
  - Response: `timeout_err`=1 after 8 wait cycles and stays 1. A later `dmem_ack` has no effect; only `reset`=0 clears it.
- Fetch bubble:
  - Stimulus: `imem_ready`=0 for 2 cycles.
  - Response: `we_pc`=0 and `flush_id`=1 for 2 cycles; `we_ex`, `we_mem`, `we_wb`=1.
- Reset mid-wait:
  - Stimulus: assert `reset`=0 during DMEM_WAIT.
  - Response: outputs drop to 0 asynchronously; RUN and normal enables follow release.
